pp_stream_checker: RTL and testbench
====================================

PP_STREAM_CHECKER -- requirements
Module: pp_stream_checker

Interface
REQ-001 The block SHALL have parameter FRAME_WORDS, default 50, giving the number of 16-bit words per frame (legal range 2..63).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of the error and frame counters.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, 25 MHz read-side domain; all logic is rising-edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port din_valid, input, 1 bit: qualifies din for the current cycle.
REQ-006 The block SHALL have port din, input, 16 bits: ping-pong buffer output word; din[7:0] is byte N and din[15:8] is byte N+1.
REQ-007 The block SHALL have port clr, input, 1 bit: synchronous clear of err_cnt and frame_cnt.
REQ-008 The block SHALL have port locked, output, 1 bit: high while the FSM is in CHECK.
REQ-009 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse when a frame completes.
REQ-010 The block SHALL have port frame_ok, output, 1 bit: valid with frame_done; high when the completed frame had no mismatch.
REQ-011 The block SHALL have port err_cnt, output, CNT_W bits: total mismatching words.
REQ-012 The block SHALL have port frame_cnt, output, CNT_W bits: total completed frames.
REQ-013 The block SHALL have port exp_byte, output, 8 bits: expected low byte of the next word.

Function
REQ-014 The FSM SHALL have two states: IDLE (unlocked) and CHECK.
REQ-015 In IDLE, a valid word with din[15:8] == din[7:0]+1 mod 256 SHALL move the FSM to CHECK on the next edge.
- On that edge: exp_byte = din[7:0]+2 mod 256, word index = 1.
- That locking word counts as word 0 of the first frame.
REQ-016 In IDLE, a valid word that fails the REQ-015 test SHALL leave the FSM in IDLE and SHALL NOT change err_cnt.
REQ-017 In CHECK, a valid word SHALL be a match iff din == {exp_byte+1, exp_byte} mod 256.
REQ-018 On a valid mismatch in CHECK:
- err_cnt SHALL increment.
- The frame error flag SHALL be set.
- The consecutive-mismatch counter SHALL increment.
REQ-019 After every valid word in CHECK, exp_byte SHALL become din[7:0]+2 mod 256, resynchronising to the received data.
REQ-020 A valid match SHALL clear the consecutive-mismatch counter.
REQ-021 Four consecutive valid mismatches SHALL force IDLE on the edge of the fourth; that word still counts in err_cnt.
REQ-022 The word index SHALL count valid words in CHECK and wrap from FRAME_WORDS-1 to 0.
REQ-023 On the wrap of REQ-022:
- frame_done SHALL be high for exactly the next cycle.
- frame_ok SHALL equal NOT(frame error flag OR current-word mismatch).
- frame_cnt SHALL increment.
- The frame error flag SHALL clear.
REQ-024 Cycles with din_valid low SHALL change no state; frame_done SHALL be low during them.
REQ-025 Byte arithmetic SHALL wrap: low byte 0xFE expects word 0xFFFE, and the next expected word is 0x0100.
REQ-026 Leaving CHECK mid-frame SHALL discard the partial frame: no frame_done, and the word index and frame error flag clear.
REQ-027 If clr and a counter increment occur in the same cycle, the counter SHALL load 1.
REQ-028 Latency: every output SHALL update on the clock edge that samples the valid word (one register stage), with no combinational path from din to any output.

Reset
REQ-029 While rst is high, the block SHALL hold: state IDLE, locked=0, frame_done=0, frame_ok=0, err_cnt=0, frame_cnt=0, exp_byte=0x00, word index 0, mismatch counter 0, frame error flag 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately, with no frame_done on exit; after release the block SHALL relock per REQ-015.

Configuration
REQ-031 With macro PP_CHK_SAT_EN defined, err_cnt and frame_cnt SHALL saturate at 2^CNT_W-1.
REQ-032 Without PP_CHK_SAT_EN, err_cnt and frame_cnt SHALL wrap modulo 2^CNT_W.

Verification
REQ-033 Lock and frame: 50 consecutive valid words 0x0100, 0x0302, ... -> locked=1 after word 1; frame_done pulse with frame_ok=1 after word 50; frame_cnt=1, err_cnt=0.
REQ-034 Wrap: lock on 0xFFFE, then 0x0100 -> no error; exp_byte=0x02.
REQ-035 Single error: word 10 corrupted to 0xAAAA in a 50-word frame -> err_cnt=1; frame_ok=0 at frame end; the next frame is clean with frame_ok=1.
REQ-036 Lock loss: four consecutive bad words after lock -> locked=0 on the fourth edge, err_cnt=4, no frame_done.
REQ-037 Gaps and reset: din_valid toggled 1/0 over a 50-word frame -> a single frame_done; rst pulsed at word 25 of the next frame -> all outputs 0 and no frame_done.
REQ-038 Config: CNT_W=2, five bad-word bursts -> err_cnt=3 with PP_CHK_SAT_EN defined, err_cnt=1 without.

Source files
------------

// File: rtl/pp_stream_checker.sv
// ---------------------------------------------------------------------------
// pp_stream_checker
//
// Checks the word stream that is read out of the ping-pong buffer.
// The data is an incrementing byte pattern that is packed two bytes per
// 16-bit word (low byte N, high byte N+1). The checker first locks onto
// the pattern, then compares every valid word against the expected word.
// It counts mismatching words and completed frames, and reports a per-frame
// pass/fail pulse.
//
// Parameters
//   FRAME_WORDS : 16-bit words per frame (2..63), default 50
//   CNT_W       : width of err_cnt / frame_cnt, default 16
//
// Ports
//   clk        : single rising-edge clock (25 MHz read-side domain)
//   rst        : asynchronous active-high reset
//   din_valid  : qualifies din for the current cycle
//   din        : buffer output word, din[7:0] = byte N, din[15:8] = byte N+1
//   clr        : synchronous clear of err_cnt and frame_cnt
//   locked     : high while the checker is in CHECK
//   frame_done : one-cycle pulse when a frame completes
//   frame_ok   : qualified by frame_done, high when that frame was clean
//   err_cnt    : total number of mismatching words
//   frame_cnt  : total number of completed frames
//   exp_byte   : expected low byte of the next word
//
// Configuration macro
//   PP_CHK_SAT_EN : when defined, err_cnt and frame_cnt saturate at their
//                   maximum value. Otherwise they wrap around.
//
// Every output comes straight from a register, so din has no
// combinational path to any output.
// ---------------------------------------------------------------------------
module pp_stream_checker #(
  parameter int FRAME_WORDS = 50,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic [15:0]      din,
  input  logic             clr,
  output logic             locked,
  output logic             frame_done,
  output logic             frame_ok,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [7:0]       exp_byte
);

  localparam int               IDX_W    = $clog2(FRAME_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WORDS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CHECK = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] word_idx, word_idx_nxt;
  logic [1:0]       mm_cnt, mm_cnt_nxt;
  logic             frame_err, frame_err_nxt;
  logic [7:0]       exp_byte_nxt;
  logic             frame_done_nxt;
  logic             frame_ok_nxt;
  logic [CNT_W-1:0] err_cnt_nxt;
  logic [CNT_W-1:0] frame_cnt_nxt;
  logic             err_inc;
  logic             frame_inc;

  logic [7:0]       din_lo;
  logic [7:0]       din_hi;
  logic             lock_hit;
  logic             word_match;
  logic             lose_lock;

  // Split the incoming word into its two pattern bytes. All byte arithmetic
  // is 8 bits wide, so 0xFF + 1 wraps to 0x00.
  assign din_lo = din[7:0];
  assign din_hi = din[15:8];

  // A word can start a lock when its high byte follows its low byte. This
  // test does not depend on any earlier history.
  assign lock_hit = (din_hi == (din_lo + 8'd1));

  // While locked, a word matches when it equals the pair predicted from
  // the previous word.
  assign word_match = (din_lo == exp_byte) && (din_hi == (exp_byte + 8'd1));

  // The fourth mismatch in a row drops the lock. mm_cnt counts the earlier
  // mismatches, so a value of 3 means this word is the fourth.
  assign lose_lock = !word_match && (mm_cnt == 2'd3);

  // The locked flag is decoded from the state register only.
  assign locked = (state == CHECK);

  // Counter step. The increment either stops at the all-ones value or
  // wraps, depending on the build configuration.
  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
`ifdef PP_CHK_SAT_EN
    bump = (&v) ? v : v + 1'b1;
`else
    bump = v + 1'b1;
`endif
  endfunction

  // Next-state and datapath decode. Each valid word in CHECK
  // resynchronises exp_byte to the received data. A single corrupted
  // word therefore causes one error, not a run of errors. When the lock
  // is lost mid-frame, the partial frame is dropped silently.
  always_comb begin
    state_nxt      = state;
    word_idx_nxt   = word_idx;
    mm_cnt_nxt     = mm_cnt;
    frame_err_nxt  = frame_err;
    exp_byte_nxt   = exp_byte;
    frame_done_nxt = 1'b0;
    frame_ok_nxt   = frame_ok;
    err_inc        = 1'b0;
    frame_inc      = 1'b0;

    case (state)
      IDLE: begin
        if (din_valid && lock_hit) begin
          state_nxt     = CHECK;
          exp_byte_nxt  = din_lo + 8'd2;
          word_idx_nxt  = IDX_W'(1);
          mm_cnt_nxt    = 2'd0;
          frame_err_nxt = 1'b0;
        end
      end

      CHECK: begin
        if (din_valid) begin
          exp_byte_nxt = din_lo + 8'd2;
          err_inc      = !word_match;

          if (lose_lock) begin
            state_nxt     = IDLE;
            word_idx_nxt  = '0;
            mm_cnt_nxt    = 2'd0;
            frame_err_nxt = 1'b0;
          end else begin
            mm_cnt_nxt = word_match ? 2'd0 : mm_cnt + 2'd1;

            if (word_idx == LAST_IDX) begin
              word_idx_nxt   = '0;
              frame_done_nxt = 1'b1;
              frame_ok_nxt   = !(frame_err || !word_match);
              frame_inc      = 1'b1;
              frame_err_nxt  = 1'b0;
            end else begin
              word_idx_nxt  = word_idx + 1'b1;
              frame_err_nxt = frame_err || !word_match;
            end
          end
        end
      end
    endcase
  end

  // Counter update. If clr and an increment occur in the same cycle, the
  // counter loads 1, so the event that happens together with the clear
  // is still counted.
  always_comb begin
    err_cnt_nxt   = err_cnt;
    frame_cnt_nxt = frame_cnt;

    if (err_inc) begin
      err_cnt_nxt = clr ? CNT_W'(1) : bump(err_cnt);
    end else if (clr) begin
      err_cnt_nxt = '0;
    end

    if (frame_inc) begin
      frame_cnt_nxt = clr ? CNT_W'(1) : bump(frame_cnt);
    end else if (clr) begin
      frame_cnt_nxt = '0;
    end
  end

  // Register stage for the state and every output. Reset clears the
  // frame in progress at once, so no frame_done pulse can follow a reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      word_idx   <= '0;
      mm_cnt     <= 2'd0;
      frame_err  <= 1'b0;
      exp_byte   <= 8'h00;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      err_cnt    <= '0;
      frame_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      word_idx   <= word_idx_nxt;
      mm_cnt     <= mm_cnt_nxt;
      frame_err  <= frame_err_nxt;
      exp_byte   <= exp_byte_nxt;
      frame_done <= frame_done_nxt;
      frame_ok   <= frame_ok_nxt;
      err_cnt    <= err_cnt_nxt;
      frame_cnt  <= frame_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_pp_stream_checker.sv
// ---------------------------------------------------------------------------
// tb_pp_stream_checker
//
// Directed testbench for pp_stream_checker. The main instance uses the
// default parameters. A second, narrow instance (CNT_W=2, FRAME_WORDS=4)
// shares the same inputs and is used to check counter overflow. Expected
// values are worked out by hand from the incrementing byte pattern. The
// bench variable next_lo tracks the low byte the design should expect
// next.
// ---------------------------------------------------------------------------
module tb_pp_stream_checker;

  logic        clk;
  logic        rst;
  logic        din_valid;
  logic [15:0] din;
  logic        clr;

  logic        locked;
  logic        frame_done;
  logic        frame_ok;
  logic [15:0] err_cnt;
  logic [15:0] frame_cnt;
  logic [7:0]  exp_byte;

  logic        s_locked;
  logic        s_frame_done;
  logic        s_frame_ok;
  logic [1:0]  s_err_cnt;
  logic [1:0]  s_frame_cnt;
  logic [7:0]  s_exp_byte;

  int          total;
  int          bad;
  logic [7:0]  next_lo;

  // Expected narrow-counter value after five increments.
`ifdef PP_CHK_SAT_EN
  localparam logic [1:0] FIVE_INCS = 2'd3;
`else
  localparam logic [1:0] FIVE_INCS = 2'd1;
`endif

  pp_stream_checker #(.FRAME_WORDS(50), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .din_valid  (din_valid),
    .din        (din),
    .clr        (clr),
    .locked     (locked),
    .frame_done (frame_done),
    .frame_ok   (frame_ok),
    .err_cnt    (err_cnt),
    .frame_cnt  (frame_cnt),
    .exp_byte   (exp_byte)
  );

  pp_stream_checker #(.FRAME_WORDS(4), .CNT_W(2)) dut_small (
    .clk        (clk),
    .rst        (rst),
    .din_valid  (din_valid),
    .din        (din),
    .clr        (clr),
    .locked     (s_locked),
    .frame_done (s_frame_done),
    .frame_ok   (s_frame_ok),
    .err_cnt    (s_err_cnt),
    .frame_cnt  (s_frame_cnt),
    .exp_byte   (s_exp_byte)
  );

  // 25 MHz clock
  always #20 clk = ~clk;

  // Drive one cycle of input on the falling edge. Outputs are sampled 1 ns
  // after the rising edge that registers this cycle.
  task automatic apply_stimulus(input logic v, input logic [15:0] d, input logic c);
    @(negedge clk);
    din_valid = v;
    din       = d;
    clr       = c;
    @(posedge clk);
    #1;
  endtask

  // Send one valid word and update the bench's expected next low byte.
  task automatic send_word(input logic [15:0] d, input logic c);
    apply_stimulus(1'b1, d, c);
    next_lo = d[7:0] + 8'd2;
  endtask

  function automatic logic [15:0] good_word();
    logic [7:0] hi;
    hi = next_lo + 8'd1;
    return {hi, next_lo};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    din_valid = 1'b0;
    clr       = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    next_lo = 8'h00;
  endtask

  task automatic test_reset();
    total++; if (locked !== 1'b0) begin bad++; $display("[TB] FAIL reset_locked got=%0h exp=0", locked); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_frame_done got=%0h exp=0", frame_done); end
    total++; if (frame_ok !== 1'b0) begin bad++; $display("[TB] FAIL reset_frame_ok got=%0h exp=0", frame_ok); end
    total++; if (err_cnt !== 16'd0) begin bad++; $display("[TB] FAIL reset_err_cnt got=%0h exp=0", err_cnt); end
    total++; if (frame_cnt !== 16'd0) begin bad++; $display("[TB] FAIL reset_frame_cnt got=%0h exp=0", frame_cnt); end
    total++; if (exp_byte !== 8'h00) begin bad++; $display("[TB] FAIL reset_exp_byte got=%0h exp=0", exp_byte); end
  endtask

  task automatic test_lock_frame();
    int done_seen;
    do_reset();
    done_seen = 0;
    send_word(good_word(), 1'b0);
    total++; if (locked !== 1'b1) begin bad++; $display("[TB] FAIL lock_first_word got=%0h exp=1", locked); end
    total++; if (exp_byte !== 8'h02) begin bad++; $display("[TB] FAIL lock_exp_byte got=%0h exp=02", exp_byte); end
    for (int k = 1; k < 49; k++) begin
      send_word(good_word(), 1'b0);
      if (frame_done === 1'b1) done_seen++;
    end
    total++; if (done_seen !== 0) begin bad++; $display("[TB] FAIL lock_early_done got=%0d exp=0", done_seen); end
    send_word(good_word(), 1'b0);
    total++; if (frame_done !== 1'b1) begin bad++; $display("[TB] FAIL frame_done_word50 got=%0h exp=1", frame_done); end
    total++; if (frame_ok !== 1'b1) begin bad++; $display("[TB] FAIL frame_ok_clean got=%0h exp=1", frame_ok); end
    total++; if (frame_cnt !== 16'd1) begin bad++; $display("[TB] FAIL frame_cnt_one got=%0h exp=1", frame_cnt); end
    total++; if (err_cnt !== 16'd0) begin bad++; $display("[TB] FAIL err_cnt_clean got=%0h exp=0", err_cnt); end
    total++; if (exp_byte !== 8'h64) begin bad++; $display("[TB] FAIL exp_byte_frame_end got=%0h exp=64", exp_byte); end
    apply_stimulus(1'b0, 16'hAAAA, 1'b0);
    total++; if (frame_done !== 1'b0) begin bad++; $display("[TB] FAIL frame_done_one_cycle got=%0h exp=0", frame_done); end
    total++; if (exp_byte !== 8'h64) begin bad++; $display("[TB] FAIL gap_holds_exp got=%0h exp=64", exp_byte); end
  endtask

  task automatic test_wrap();
    do_reset();
    send_word(16'hFFFE, 1'b0);
    total++; if (locked !== 1'b1) begin bad++; $display("[TB] FAIL wrap_lock got=%0h exp=1", locked); end
    total++; if (exp_byte !== 8'h00) begin bad++; $display("[TB] FAIL wrap_exp_after_fe got=%0h exp=00", exp_byte); end
    send_word(16'h0100, 1'b0);
    total++; if (err_cnt !== 16'd0) begin bad++; $display("[TB] FAIL wrap_no_error got=%0h exp=0", err_cnt); end
    total++; if (exp_byte !== 8'h02) begin bad++; $display("[TB] FAIL wrap_exp_02 got=%0h exp=02", exp_byte); end
  endtask

  task automatic test_single_error();
    int done_seen;
    do_reset();
    done_seen = 0;
    send_word(good_word(), 1'b0);
    for (int k = 1; k < 49; k++) begin
      if (k == 10) begin
        send_word(16'hAAAA, 1'b0);
        total++; if (err_cnt !== 16'd1) begin bad++; $display("[TB] FAIL single_err_count got=%0h exp=1", err_cnt); end
      end else begin
        send_word(good_word(), 1'b0);
      end
      if (frame_done === 1'b1) done_seen++;
    end
    total++; if (done_seen !== 0) begin bad++; $display("[TB] FAIL single_early_done got=%0d exp=0", done_seen); end
    send_word(good_word(), 1'b0);
    total++; if (frame_done !== 1'b1) begin bad++; $display("[TB] FAIL single_done got=%0h exp=1", frame_done); end
    total++; if (frame_ok !== 1'b0) begin bad++; $display("[TB] FAIL single_frame_ok got=%0h exp=0", frame_ok); end
    total++; if (err_cnt !== 16'd1) begin bad++; $display("[TB] FAIL single_err_at_end got=%0h exp=1", err_cnt); end
    for (int k = 0; k < 50; k++) send_word(good_word(), 1'b0);
    total++; if (frame_done !== 1'b1) begin bad++; $display("[TB] FAIL clean_next_done got=%0h exp=1", frame_done); end
    total++; if (frame_ok !== 1'b1) begin bad++; $display("[TB] FAIL clean_next_ok got=%0h exp=1", frame_ok); end
    total++; if (frame_cnt !== 16'd2) begin bad++; $display("[TB] FAIL clean_next_cnt got=%0h exp=2", frame_cnt); end
    for (int k = 0; k < 49; k++) send_word(good_word(), 1'b0);
    send_word(16'hAAAA, 1'b0);
    total++; if (frame_ok !== 1'b0) begin bad++; $display("[TB] FAIL last_word_bad_ok got=%0h exp=0", frame_ok); end
    total++; if (frame_done !== 1'b1) begin bad++; $display("[TB] FAIL last_word_bad_done got=%0h exp=1", frame_done); end
    total++; if (err_cnt !== 16'd2) begin bad++; $display("[TB] FAIL last_word_bad_err got=%0h exp=2", err_cnt); end
    total++; if (frame_cnt !== 16'd3) begin bad++; $display("[TB] FAIL last_word_bad_cnt got=%0h exp=3", frame_cnt); end
  endtask

  task automatic test_lock_loss();
    int done_seen;
    do_reset();
    done_seen = 0;
    for (int k = 0; k < 3; k++) send_word(good_word(), 1'b0);
    for (int k = 0; k < 3; k++) begin
      send_word(16'hAAAA, 1'b0);
      if (frame_done === 1'b1) done_seen++;
    end
    total++; if (locked !== 1'b1) begin bad++; $display("[TB] FAIL loss_after_three got=%0h exp=1", locked); end
    send_word(16'hAAAA, 1'b0);
    if (frame_done === 1'b1) done_seen++;
    total++; if (locked !== 1'b0) begin bad++; $display("[TB] FAIL loss_after_four got=%0h exp=0", locked); end
    total++; if (err_cnt !== 16'd4) begin bad++; $display("[TB] FAIL loss_err_cnt got=%0h exp=4", err_cnt); end
    total++; if (done_seen !== 0) begin bad++; $display("[TB] FAIL loss_no_done got=%0d exp=0", done_seen); end
    send_word(16'h1234, 1'b0);
    total++; if (err_cnt !== 16'd4) begin bad++; $display("[TB] FAIL idle_no_err got=%0h exp=4", err_cnt); end
    total++; if (locked !== 1'b0) begin bad++; $display("[TB] FAIL idle_stays got=%0h exp=0", locked); end
    send_word(16'h0504, 1'b0);
    total++; if (locked !== 1'b1) begin bad++; $display("[TB] FAIL relock got=%0h exp=1", locked); end
    for (int k = 0; k < 3; k++) send_word(16'hAAAA, 1'b0);
    send_word(good_word(), 1'b0);
    for (int k = 0; k < 3; k++) send_word(16'hAAAA, 1'b0);
    total++; if (locked !== 1'b1) begin bad++; $display("[TB] FAIL match_resets_run got=%0h exp=1", locked); end
    total++; if (err_cnt !== 16'd10) begin bad++; $display("[TB] FAIL run_err_cnt got=%0h exp=10", err_cnt); end
    send_word(16'hAAAA, 1'b0);
    total++; if (locked !== 1'b0) begin bad++; $display("[TB] FAIL second_loss got=%0h exp=0", locked); end
  endtask

  task automatic test_gaps_reset();
    int done_seen;
    int gap_done;
    do_reset();
    done_seen = 0;
    gap_done  = 0;
    for (int k = 0; k < 50; k++) begin
      send_word(good_word(), 1'b0);
      if (frame_done === 1'b1) done_seen++;
      apply_stimulus(1'b0, 16'hAAAA, 1'b0);
      if (frame_done === 1'b1) gap_done++;
    end
    total++; if (done_seen !== 1) begin bad++; $display("[TB] FAIL gaps_single_done got=%0d exp=1", done_seen); end
    total++; if (gap_done !== 0) begin bad++; $display("[TB] FAIL gaps_done_low got=%0d exp=0", gap_done); end
    total++; if (err_cnt !== 16'd0) begin bad++; $display("[TB] FAIL gaps_no_err got=%0h exp=0", err_cnt); end
    total++; if (frame_cnt !== 16'd1) begin bad++; $display("[TB] FAIL gaps_frame_cnt got=%0h exp=1", frame_cnt); end
    total++; if (frame_ok !== 1'b1) begin bad++; $display("[TB] FAIL gaps_frame_ok got=%0h exp=1", frame_ok); end
    for (int k = 0; k < 25; k++) send_word(good_word(), 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (locked !== 1'b0) begin bad++; $display("[TB] FAIL midrst_locked got=%0h exp=0", locked); end
    total++; if (frame_ok !== 1'b0) begin bad++; $display("[TB] FAIL midrst_frame_ok got=%0h exp=0", frame_ok); end
    total++; if (frame_cnt !== 16'd0) begin bad++; $display("[TB] FAIL midrst_frame_cnt got=%0h exp=0", frame_cnt); end
    total++; if (exp_byte !== 8'h00) begin bad++; $display("[TB] FAIL midrst_exp_byte got=%0h exp=0", exp_byte); end
    din_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    apply_stimulus(1'b0, 16'h0000, 1'b0);
    total++; if (frame_done !== 1'b0) begin bad++; $display("[TB] FAIL midrst_no_done got=%0h exp=0", frame_done); end
    send_word(16'h1110, 1'b0);
    total++; if (locked !== 1'b1) begin bad++; $display("[TB] FAIL post_rst_relock got=%0h exp=1", locked); end
    total++; if (exp_byte !== 8'h12) begin bad++; $display("[TB] FAIL post_rst_exp got=%0h exp=12", exp_byte); end
  endtask

  task automatic test_clr();
    do_reset();
    send_word(good_word(), 1'b0);
    send_word(16'hAAAA, 1'b0);
    send_word(16'hAAAA, 1'b0);
    total++; if (err_cnt !== 16'd2) begin bad++; $display("[TB] FAIL clr_pre_err got=%0h exp=2", err_cnt); end
    send_word(good_word(), 1'b1);
    total++; if (err_cnt !== 16'd0) begin bad++; $display("[TB] FAIL clr_plain got=%0h exp=0", err_cnt); end
    send_word(16'hAAAA, 1'b1);
    total++; if (err_cnt !== 16'd1) begin bad++; $display("[TB] FAIL clr_with_err_inc got=%0h exp=1", err_cnt); end
    for (int k = 5; k < 49; k++) send_word(good_word(), 1'b0);
    send_word(good_word(), 1'b1);
    total++; if (frame_done !== 1'b1) begin bad++; $display("[TB] FAIL clr_frame_done got=%0h exp=1", frame_done); end
    total++; if (frame_cnt !== 16'd1) begin bad++; $display("[TB] FAIL clr_with_frame_inc got=%0h exp=1", frame_cnt); end
    total++; if (frame_ok !== 1'b0) begin bad++; $display("[TB] FAIL clr_frame_ok got=%0h exp=0", frame_ok); end
    total++; if (err_cnt !== 16'd0) begin bad++; $display("[TB] FAIL clr_err_end got=%0h exp=0", err_cnt); end
  endtask

  task automatic test_config();
    do_reset();
    send_word(good_word(), 1'b0);
    for (int k = 0; k < 5; k++) begin
      send_word(16'hAAAA, 1'b0);
      send_word(good_word(), 1'b0);
    end
    total++; if (err_cnt !== 16'd5) begin bad++; $display("[TB] FAIL cfg_main_err got=%0h exp=5", err_cnt); end
    total++; if (s_err_cnt !== FIVE_INCS) begin bad++; $display("[TB] FAIL cfg_small_err got=%0h exp=%0h", s_err_cnt, FIVE_INCS); end
    for (int k = 0; k < 11; k++) send_word(good_word(), 1'b0);
    total++; if (s_frame_cnt !== FIVE_INCS) begin bad++; $display("[TB] FAIL cfg_small_frames got=%0h exp=%0h", s_frame_cnt, FIVE_INCS); end
    total++; if (frame_cnt !== 16'd0) begin bad++; $display("[TB] FAIL cfg_main_frames got=%0h exp=0", frame_cnt); end
  endtask

  initial begin
    clk       = 1'b0;
    rst       = 1'b1;
    din_valid = 1'b0;
    din       = 16'h0000;
    clr       = 1'b0;
    total     = 0;
    bad       = 0;
    next_lo   = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_lock_frame();
    test_wrap();
    test_single_error();
    test_lock_loss();
    test_gaps_reset();
    test_clr();
    test_config();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
